// File: rtl/watchdog_ctrl.sv
// Shared watchdog: clients arm/kick/disarm one time-out counter; on expiry a
// grace counter runs and, without an acknowledge, escalates to a sticky hung.
module watchdog_ctrl #(
    parameter int NUM_CLIENTS        = 4,
    parameter int COUNTER_WIDTH      = 32,
    parameter int POST_COUNTER_WIDTH = 8,
    parameter int DEFAULT_TIMEOUT    = 10000,
    parameter int DEFAULT_POST       = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    input  logic [COUNTER_WIDTH-1:0]      cfg_timeout,
    input  logic [POST_COUNTER_WIDTH-1:0] cfg_post,
    output logic                          cfg_ready,
    input  logic [NUM_CLIENTS-1:0]        arm,
    input  logic [NUM_CLIENTS-1:0]        disarm,
    input  logic [NUM_CLIENTS-1:0]        kick,
    input  logic                          timeout_ack,
    output logic                          timeout,
    output logic                          hung,
    output logic [NUM_CLIENTS-1:0]        armed_mask,
    output logic [NUM_CLIENTS-1:0]        expired_mask,
    output logic [COUNTER_WIDTH-1:0]      count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;
    localparam logic [1:0] ST_HUNG    = 2'd3;

    localparam logic [COUNTER_WIDTH-1:0]      ONE_T = COUNTER_WIDTH'(1);
    localparam logic [POST_COUNTER_WIDTH-1:0] ONE_P = POST_COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0]      DEF_T =
        (DEFAULT_TIMEOUT == 0) ? ONE_T : COUNTER_WIDTH'(DEFAULT_TIMEOUT);
    localparam logic [POST_COUNTER_WIDTH-1:0] DEF_P =
        (DEFAULT_POST == 0) ? ONE_P : POST_COUNTER_WIDTH'(DEFAULT_POST);

    logic [1:0]                    state_q, state_d;
    logic [COUNTER_WIDTH-1:0]      reload_q, reload_d;
    logic [POST_COUNTER_WIDTH-1:0] post_reload_q, post_reload_d;
    logic [COUNTER_WIDTH-1:0]      count_q, count_d;
    logic [POST_COUNTER_WIDTH-1:0] post_q, post_d;
    logic                          timeout_q, timeout_d;
    logic                          hung_q, hung_d;
    logic [NUM_CLIENTS-1:0]        armed_q, armed_d;
    logic [NUM_CLIENTS-1:0]        expired_q, expired_d;

    logic [NUM_CLIENTS-1:0]        armed_next;
    logic                          cfg_accept;
    logic [COUNTER_WIDTH-1:0]      cfg_timeout_sat;
    logic [POST_COUNTER_WIDTH-1:0] cfg_post_sat;

    // Arm wins over a simultaneous disarm of the same client.
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_arm
        assign armed_next[gi] = arm[gi] | (armed_q[gi] & ~disarm[gi]);
    end

    assign cfg_accept      = cfg_valid && (state_q == ST_IDLE);
    assign cfg_timeout_sat = (cfg_timeout == '0) ? ONE_T : cfg_timeout;
    assign cfg_post_sat    = (cfg_post == '0) ? ONE_P : cfg_post;

    always_comb begin
        state_d       = state_q;
        reload_d      = reload_q;
        post_reload_d = post_reload_q;
        count_d       = count_q;
        post_d        = post_q;
        timeout_d     = timeout_q;
        hung_d        = hung_q;
        armed_d       = armed_q;
        expired_d     = expired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_accept) begin
                    reload_d      = cfg_timeout_sat;
                    post_reload_d = cfg_post_sat;
                end
                count_d = reload_d;
                armed_d = armed_next;
                if (|arm) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                armed_d = armed_next;
                if (armed_next == '0) begin
                    state_d = ST_IDLE;
                    count_d = reload_q;
                end else if ((|(kick & armed_next)) || (|arm)) begin
                    count_d = reload_q;
                end else if (count_q == ONE_T) begin
                    state_d   = ST_EXPIRED;
                    timeout_d = 1'b1;
                    expired_d = armed_q;
                    post_d    = post_reload_q;
                end else begin
                    count_d = count_q - ONE_T;
                end
            end
            ST_EXPIRED: begin
                if (timeout_ack) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b0;
                    armed_d   = '0;
                    count_d   = reload_q;
                end else if (post_q == ONE_P) begin
                    state_d = ST_HUNG;
                    hung_d  = 1'b1;
                end else begin
                    post_d = post_q - ONE_P;
                end
            end
            default: begin
                // HUNG holds everything until reset.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            reload_q      <= DEF_T;
            post_reload_q <= DEF_P;
            count_q       <= DEF_T;
            post_q        <= DEF_P;
            timeout_q     <= 1'b0;
            hung_q        <= 1'b0;
            armed_q       <= '0;
            expired_q     <= '0;
        end else begin
            state_q       <= state_d;
            reload_q      <= reload_d;
            post_reload_q <= post_reload_d;
            count_q       <= count_d;
            post_q        <= post_d;
            timeout_q     <= timeout_d;
            hung_q        <= hung_d;
            armed_q       <= armed_d;
            expired_q     <= expired_d;
        end
    end

    assign cfg_ready    = (state_q == ST_IDLE) && !reset;
    assign timeout      = timeout_q;
    assign hung         = hung_q;
    assign armed_mask   = armed_q;
    assign expired_mask = expired_q;
    assign count        = count_q;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Bench for watchdog_ctrl: directed scenarios then random traffic, checked
// every cycle against a deadline-based model (absolute edge numbers, no counters).
module tb_watchdog_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;
    localparam int M_HUNG = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [31:0] cfg_timeout;
    logic [7:0]  cfg_post;
    logic        cfg_ready;
    logic [3:0]  arm, disarm, kick;
    logic        timeout_ack;
    logic        timeout, hung;
    logic [3:0]  armed_mask, expired_mask;
    logic [31:0] count;

    int total = 0;
    int bad   = 0;

    // Model state: edges are numbered; a reload at edge k means expiry at k+T.
    int         m_mode;
    longint     m_reload, m_post, m_start, m_tstart, ecount;
    logic [3:0] m_armed, m_expm;

    always #5 clk = ~clk;

    watchdog_ctrl dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_timeout(cfg_timeout),
        .cfg_post(cfg_post), .cfg_ready(cfg_ready), .arm(arm), .disarm(disarm),
        .kick(kick), .timeout_ack(timeout_ack), .timeout(timeout), .hung(hung),
        .armed_mask(armed_mask), .expired_mask(expired_mask), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, ecount);
        end
    endtask

    task automatic step(input logic cv, input logic [31:0] ct, input logic [7:0] cp,
                        input logic [3:0] a, input logic [3:0] d, input logic [3:0] k,
                        input logic ack, input logic rst);
        longint     e;
        logic [3:0] nxt;
        logic [31:0] exp_cnt;
        cfg_valid = cv; cfg_timeout = ct; cfg_post = cp;
        arm = a; disarm = d; kick = k; timeout_ack = ack; reset = rst;

        e = ecount + 1;
        if (rst) begin
            m_mode = M_IDLE; m_reload = 10000; m_post = 100; m_armed = 0; m_expm = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (cv) begin
                        m_reload = (ct == 0) ? 1 : longint'(ct);
                        m_post   = (cp == 0) ? 1 : longint'(cp);
                    end
                    m_armed = (m_armed & ~d) | a;
                    if (a != 0) begin
                        m_mode = M_RUN; m_start = e;
                    end
                end
                M_RUN: begin
                    nxt = (m_armed & ~d) | a;
                    if (nxt == 0) m_mode = M_IDLE;
                    else if ((k & nxt) != 0 || a != 0) m_start = e;
                    else if (e == m_start + m_reload) begin
                        m_mode = M_EXP; m_expm = m_armed; m_tstart = e;
                    end
                    m_armed = nxt;
                end
                M_EXP: begin
                    if (ack) begin
                        m_mode = M_IDLE; m_armed = 0;
                    end else if (e == m_tstart + m_post) m_mode = M_HUNG;
                end
                default: ;
            endcase
        end
        ecount = e;

        @(posedge clk);
        #1;
        case (m_mode)
            M_IDLE:  exp_cnt = 32'(m_reload);
            M_RUN:   exp_cnt = 32'(m_reload - (ecount - m_start));
            default: exp_cnt = 32'd1;
        endcase
        $display("e=%0d rst=%b cfg=%b arm=%b dis=%b kick=%b ack=%b -> to=%b hung=%b armed=%b exp=%b cnt=%0d rdy=%b",
                 ecount, rst, cv, a, d, k, ack, timeout, hung, armed_mask, expired_mask, count, cfg_ready);
        check("timeout", 32'(timeout), 32'(m_mode == M_EXP || m_mode == M_HUNG));
        check("hung", 32'(hung), 32'(m_mode == M_HUNG));
        check("armed_mask", 32'(armed_mask), 32'(m_armed));
        check("expired_mask", 32'(expired_mask), 32'(m_expm));
        check("count", count, exp_cnt);
        check("cfg_ready", 32'(cfg_ready), 32'(m_mode == M_IDLE && !rst));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_mode = M_IDLE; m_reload = 10000; m_post = 100; m_start = 0; m_tstart = 0;
        ecount = 0; m_armed = 0; m_expm = 0;

        // Post-reset defaults
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("reset_count", count, 32'd10000);
        check("reset_ready", 32'(cfg_ready), 32'd1);

        // Configure then expire: timeout at a+20, hung at a+25
        step(1, 20, 5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 4'b0001, 0, 0, 0, 0);
        idle(19);
        check("pre_expiry_timeout", 32'(timeout), 32'd0);
        idle(1);
        check("expiry_timeout", 32'(timeout), 32'd1);
        check("expiry_mask", 32'(expired_mask), 32'd1);
        idle(4);
        check("pre_hung", 32'(hung), 32'd0);
        idle(1);
        check("hung_rise", 32'(hung), 32'd1);
        idle(3);

        // Kicks and masking
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 10, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 4'b0011, 0, 0, 0, 0);
        for (int i = 1; i <= 50; i++) step(0, 0, 0, 0, 0, (i % 8 == 0) ? 4'b0010 : 4'b0000, 0, 0);
        check("kicked_alive", 32'(timeout), 32'd0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 4'b0100, 0, 0);
        check("unarmed_kick_pre", 32'(timeout), 32'd0);
        step(0, 0, 0, 0, 0, 4'b0100, 0, 0);
        check("unarmed_kick_expiry", 32'(timeout), 32'd1);

        // Acknowledge on the cycle the grace counter is at 1
        for (int i = 0; i < 300 && m_mode == M_EXP && ecount + 1 != m_tstart + m_post; i++) idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("ack_timeout", 32'(timeout), 32'd0);
        check("ack_hung", 32'(hung), 32'd0);
        check("ack_armed", 32'(armed_mask), 32'd0);

        // Disarm with count at 3
        step(0, 0, 0, 4'b0001, 0, 0, 0, 0);
        for (int i = 0; i < 20 && (m_reload - (ecount - m_start)) != 3; i++) idle(1);
        check("count_at_3", count, 32'd3);
        step(0, 0, 0, 0, 4'b0001, 0, 0, 0);
        check("disarm_count", count, 32'd10);
        idle(12);
        check("disarm_no_timeout", 32'(timeout), 32'd0);

        // cfg hold-off during RUN, then accepted in IDLE; timeout 0 behaves as 1
        step(0, 0, 0, 4'b0100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        check("cfg_held", 32'(cfg_ready), 32'd0);
        step(1, 0, 0, 0, 4'b0100, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("cfg_zero_count", count, 32'd1);
        step(0, 0, 0, 4'b1000, 0, 0, 0, 0);
        idle(1);
        check("t1_timeout", 32'(timeout), 32'd1);
        idle(1);
        check("p1_hung", 32'(hung), 32'd1);
        step(0, 0, 0, 4'b1111, 0, 4'b1111, 1, 0);
        check("hung_ignores", 32'(hung), 32'd1);

        // Reset while HUNG
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_hung_to", 32'(timeout | hung), 32'd0);
        check("rst_hung_masks", 32'({armed_mask, expired_mask}), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 12), 8'($urandom_range(0, 6)),
                 ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000,
                 ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'b0000,
                 4'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
